// File: rtl/snake_engine.sv
// Grid snake: circular body buffer, latched direction, growth on apple, wall/self collision.
// Streams one CELLxCELL pixel block per draw state (erase tail, head, apple) to a 160x120 plotter.
module snake_engine #(
   parameter int         GRID_W    = 16,
   parameter int         GRID_H    = 12,
   parameter int         CELL      = 10,
   parameter int         MAXLEN    = 16,
   parameter int         INIT_LEN  = 3,
   parameter logic [2:0] SNAKE_COL = 3'b010,
   parameter logic [2:0] APPLE_COL = 3'b100,
   parameter logic [2:0] BG_COL    = 3'b000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       tick,
   input  logic [3:0] dir_req,
   input  logic [3:0] apple_x,
   input  logic [3:0] apple_y,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       apple_eaten,
   output logic       game_over,
   output logic [4:0] length,
   output logic [3:0] head_x,
   output logic [3:0] head_y
);
   localparam int PW = $clog2(MAXLEN);
   localparam int CW = $clog2(CELL);
   localparam int SW = $clog2(INIT_LEN + 1);

   typedef enum logic [2:0] {INIT, WAIT, STEP, CHECK, ERASE, HEAD, APPLE, DEAD} state_t;
   // Encoding chosen so the opposite direction is the bitwise inverse.
   typedef enum logic [1:0] {D_RIGHT, D_DOWN, D_UP, D_LEFT} dir_t;

   state_t        state, state_nxt;
   dir_t          dir, pending_dir, cur_dir, req;
   logic [3:0]    body_x [MAXLEN];
   logic [3:0]    body_y [MAXLEN];
   logic [PW-1:0] head_ptr, push_ptr, tail_idx, seg_idx;
   logic [4:0]    len;
   logic [3:0]    nxt_x, nxt_y, tl_x, tl_y, ap_x, ap_y, cx, cy;
   logic [2:0]    col;
   logic          wall, grow, drop_tail, hit, collide, arm, pix_last, drawing;
   logic [CW-1:0] xc, yc;
   logic [SW-1:0] seg;

   assign head_x   = body_x[head_ptr];
   assign head_y   = body_y[head_ptr];
   assign length   = len;
   assign pix_last = (xc == CW'(CELL - 1)) && (yc == CW'(CELL - 1));
   assign drawing  = (state inside {ERASE, HEAD, APPLE}) || (state == INIT && !arm);

   always_comb begin
      cur_dir = (state == STEP) ? pending_dir : dir;
      req     = D_LEFT;
      if (dir_req[0])      req = D_RIGHT;
      else if (dir_req[1]) req = D_DOWN;
      else if (dir_req[2]) req = D_UP;
   end

   // Self collision: the tail is ignored whenever it is about to be dropped.
   always_comb begin
      push_ptr  = PW'((int'(head_ptr) + 1) % MAXLEN);
      tail_idx  = PW'((int'(head_ptr) + MAXLEN - int'(len) + 1) % MAXLEN);
      grow      = (nxt_x == apple_x) && (nxt_y == apple_y);
      drop_tail = !grow || (int'(len) == MAXLEN);
      hit       = 1'b0;
      seg_idx   = '0;
      for (int i = 0; i < MAXLEN; i++) begin
         seg_idx = PW'((int'(head_ptr) + MAXLEN - i) % MAXLEN);
         if (i < int'(len) && !(drop_tail && i == int'(len) - 1) &&
             body_x[seg_idx] == nxt_x && body_y[seg_idx] == nxt_y)
            hit = 1'b1;
      end
      collide = wall || hit;
   end

   always_ff @(posedge Clock) begin
      if (Reset) state <= INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cx        = '0;
      cy        = '0;
      col       = BG_COL;
      case (state)
         INIT: begin
            if (int'(seg) < INIT_LEN) begin
               cx  = 4'(GRID_W / 2 - int'(seg));
               cy  = 4'(GRID_H / 2);
               col = SNAKE_COL;
            end else begin
               cx  = ap_x;
               cy  = ap_y;
               col = APPLE_COL;
            end
            if (!arm && pix_last && int'(seg) == INIT_LEN) state_nxt = WAIT;
         end
         WAIT:  if (tick) state_nxt = STEP;
         STEP:  state_nxt = CHECK;
         CHECK: state_nxt = collide ? DEAD : (grow ? HEAD : ERASE);
         ERASE: begin
            cx = tl_x;
            cy = tl_y;
            if (pix_last) state_nxt = HEAD;
         end
         HEAD: begin
            cx  = head_x;
            cy  = head_y;
            col = SNAKE_COL;
            if (pix_last) state_nxt = APPLE;
         end
         APPLE: begin
            cx  = ap_x;
            cy  = ap_y;
            col = APPLE_COL;
            if (pix_last) state_nxt = WAIT;
         end
         default: ;
      endcase
      plot        = drawing;
      x           = plot ? 8'(cx) * 8'(CELL) + 8'(xc) : 8'd0;
      y           = plot ? 7'(cy) * 7'(CELL) + 7'(yc) : 7'd0;
      colour      = plot ? col : 3'd0;
      busy        = (state != WAIT) && (state != DEAD);
      game_over   = (state == DEAD);
      apple_eaten = (state == CHECK) && !collide && grow;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         arm         <= 1'b1;
         seg         <= '0;
         xc          <= '0;
         yc          <= '0;
         dir         <= D_RIGHT;
         pending_dir <= D_RIGHT;
         head_ptr    <= PW'(INIT_LEN - 1);
         len         <= 5'(INIT_LEN);
         nxt_x       <= '0;
         nxt_y       <= '0;
         wall        <= 1'b0;
         tl_x        <= '0;
         tl_y        <= '0;
         ap_x        <= '0;
         ap_y        <= '0;
         for (int k = 0; k < MAXLEN; k++) begin
            body_x[k] <= (k < INIT_LEN) ? 4'(GRID_W / 2 + k - (INIT_LEN - 1)) : 4'd0;
            body_y[k] <= 4'(GRID_H / 2);
         end
      end else begin
         if (dir_req != 4'd0 && req != dir_t'(~cur_dir)) pending_dir <= req;
         if (drawing) begin
            if (xc == CW'(CELL - 1)) begin
               xc <= '0;
               yc <= pix_last ? '0 : yc + 1'b1;
            end else begin
               xc <= xc + 1'b1;
            end
         end
         case (state)
            INIT: begin
               if (arm) arm <= 1'b0;
               else if (pix_last && int'(seg) < INIT_LEN) begin
                  seg <= seg + 1'b1;
                  if (int'(seg) == INIT_LEN - 1) begin
                     ap_x <= apple_x;
                     ap_y <= apple_y;
                  end
               end
            end
            STEP: begin
               dir   <= pending_dir;
               nxt_x <= head_x;
               nxt_y <= head_y;
               case (pending_dir)
                  D_RIGHT: begin nxt_x <= head_x + 4'd1; wall <= (head_x == 4'(GRID_W - 1)); end
                  D_DOWN:  begin nxt_y <= head_y + 4'd1; wall <= (head_y == 4'(GRID_H - 1)); end
                  D_UP:    begin nxt_y <= head_y - 4'd1; wall <= (head_y == 4'd0); end
                  default: begin nxt_x <= head_x - 4'd1; wall <= (head_x == 4'd0); end
               endcase
            end
            CHECK: if (!collide) begin
               head_ptr         <= push_ptr;
               body_x[push_ptr] <= nxt_x;
               body_y[push_ptr] <= nxt_y;
               tl_x             <= body_x[tail_idx];
               tl_y             <= body_y[tail_idx];
               if (grow && int'(len) < MAXLEN) len <= len + 5'd1;
            end
            HEAD: if (pix_last) begin
               ap_x <= apple_x;
               ap_y <= apple_y;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a reference snake model queues every expected pixel.
module tb_snake_engine;
   logic       Clock = 1'b0, Reset = 1'b1, tick = 1'b0;
   logic [3:0] dir_req = 4'd0, apple_x = 4'd0, apple_y = 4'd0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, apple_eaten, game_over;
   logic [4:0] length;
   logic [3:0] head_x, head_y;

   snake_engine dut (
      .Clock(Clock), .Reset(Reset), .tick(tick), .dir_req(dir_req),
      .apple_x(apple_x), .apple_y(apple_y), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .apple_eaten(apple_eaten), .game_over(game_over),
      .length(length), .head_x(head_x), .head_y(head_y)
   );

   always #5 Clock = ~Clock;

   int checks = 0, errors = 0;
   int exp_q[$];
   int eaten_cnt = 0;
   int mx[17], my[17];
   int mlen, mdir, mpend;
   bit mdead;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   // Pixel packed as {x[7:0], y[6:0], colour[2:0]}.
   task automatic push_cell(input int cx, input int cy, input int col);
      for (int yc = 0; yc < 10; yc++)
         for (int xc = 0; xc < 10; xc++)
            exp_q.push_back(((cx * 10 + xc) << 10) | ((cy * 10 + yc) << 3) | col);
   endtask

   always @(negedge Clock) begin
      if (apple_eaten === 1'b1) eaten_cnt++;
      if (plot === 1'b1) begin
         if (exp_q.size() == 0) check("extra_plot", int'({x, y, colour}), -1);
         else check("pixel", int'({x, y, colour}), exp_q.pop_front());
      end
   end

   task automatic wait_idle(input int bound, output int n);
      n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(posedge Clock); #1;
         n++;
      end
      if (n >= bound) check("timeout", n, -1);
   endtask

   task automatic do_reset(input int ax, input int ay, input int hold);
      int n;
      apple_x = 4'(ax);
      apple_y = 4'(ay);
      Reset = 1'b1;
      @(posedge Clock); #1;
      exp_q.delete();
      check("rst_plot", plot, 0);
      check("rst_xyc", int'({x, y, colour}), 0);
      check("rst_over", game_over, 0);
      check("rst_eaten", apple_eaten, 0);
      check("rst_len", length, 3);
      check("rst_head", {head_x, head_y}, 8 * 16 + 6);
      check("rst_busy", busy, 1);
      for (int i = 1; i < hold; i++) begin
         @(posedge Clock); #1;
      end
      mlen = 3; mdir = 0; mpend = 0; mdead = 0;
      for (int i = 0; i < 3; i++) begin
         mx[i] = 8 - i;
         my[i] = 6;
         push_cell(mx[i], my[i], 2);
      end
      push_cell(ax, ay, 4);
      Reset = 1'b0;
      wait_idle(1000, n);
      check("init_q", exp_q.size(), 0);
      check("init_busy", busy, 0);
   endtask

   task automatic steer(input logic [3:0] req);
      int w;
      if (req != 4'd0) begin
         w = req[0] ? 0 : req[1] ? 1 : req[2] ? 2 : 3;
         if (w != 3 - mdir) mpend = w;
      end
      dir_req = req;
      @(posedge Clock); #1;
      dir_req = 4'd0;
   endtask

   task automatic model_step(output int cyc, output int eat);
      int  nx, ny;
      bit  grow, drop, hit;
      mdir = mpend;
      nx = mx[0];
      ny = my[0];
      case (mdir)
         0: nx++;
         1: ny++;
         2: ny--;
         default: nx--;
      endcase
      grow = (nx == int'(apple_x)) && (ny == int'(apple_y));
      drop = !grow || mlen == 16;
      hit = (nx < 0 || nx > 15 || ny < 0 || ny > 11);
      for (int i = 0; i < mlen; i++)
         if (!(drop && i == mlen - 1) && mx[i] == nx && my[i] == ny) hit = 1;
      if (hit) begin
         mdead = 1;
         cyc = 2;
         eat = 0;
      end else begin
         if (!grow) push_cell(mx[mlen-1], my[mlen-1], 0);
         for (int i = mlen; i > 0; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
         end
         mx[0] = nx;
         my[0] = ny;
         if (grow && mlen < 16) mlen++;
         push_cell(nx, ny, 2);
         push_cell(apple_x, apple_y, 4);
         cyc = grow ? 202 : 302;
         eat = grow ? 1 : 0;
      end
   endtask

   task automatic step(input logic [3:0] req, input string tag);
      int cyc, eat, n;
      if (req != 4'd0) steer(req);
      model_step(cyc, eat);
      eaten_cnt = 0;
      tick = 1'b1;
      @(posedge Clock); #1;
      tick = 1'b0;
      wait_idle(2000, n);
      check({tag, "_cyc"}, n, cyc);
      check({tag, "_eaten"}, eaten_cnt, eat);
      check({tag, "_len"}, length, mlen);
      check({tag, "_head"}, {head_x, head_y}, mx[0] * 16 + my[0]);
      check({tag, "_over"}, game_over, mdead ? 1 : 0);
      check({tag, "_q"}, exp_q.size(), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

   initial begin
      int cyc, eat;
      // Initial draw, plain step, ignored reversal, turn down with priority.
      do_reset(12, 3, 2);
      step(4'b0000, "plain");
      step(4'b1000, "reverse");
      step(4'b0110, "down");
      // Growth onto the apple.
      do_reset(10, 6, 2);
      step(4'b0000, "pre_grow");
      step(4'b0000, "grow");
      // Right wall, then ticks in DEAD are ignored.
      do_reset(0, 0, 2);
      for (int i = 0; i < 7; i++) step(4'b0000, "to_wall");
      step(4'b0000, "wall");
      tick = 1'b1;
      @(posedge Clock); #1;
      tick = 1'b0;
      repeat (10) @(posedge Clock);
      #1;
      check("dead_over", game_over, 1);
      check("dead_busy", busy, 0);
      check("dead_q", exp_q.size(), 0);
      // Length-5 loop turning into its own body.
      do_reset(9, 6, 2);
      step(4'b0000, "grow4");
      apple_x = 4'd10;
      step(4'b0000, "grow5");
      apple_x = 4'd0; apple_y = 4'd0;
      step(4'b0010, "loop_down");
      step(4'b1000, "loop_left");
      step(4'b0100, "self_hit");
      // Head moving into the cell the tail is vacating.
      do_reset(9, 6, 2);
      step(4'b0000, "g4");
      apple_x = 4'd0; apple_y = 4'd0;
      step(4'b0010, "sq_down");
      step(4'b1000, "sq_left");
      step(4'b0100, "tail_chase");
      // Reset in the middle of the tail erase.
      do_reset(12, 3, 2);
      model_step(cyc, eat);
      tick = 1'b1;
      @(posedge Clock); #1;
      tick = 1'b0;
      repeat (39) @(posedge Clock);
      #1;
      do_reset(12, 3, 1);
      step(4'b0000, "after_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
